// File: rtl/conv_unzero.sv
// conv_unzero: input-side zero-point removal for the conv datapath.
//
// Takes a frame of unsigned 8-bit activation beats, subtracts the layer zero
// point from every lane and emits signed 16-bit lanes. The lane packing matches
// what the output requantizer consumes.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   Start         one-cycle frame start, honoured only in IDLE
//   beat_total    beats in the frame, sampled with Start (0 behaves as 1)
//   zero_data_in  unsigned zero point, sampled with Start
//   S_Valid/S_Ready/S_Data        input beat stream, L lanes x 8 bits
//   M_Valid/M_Ready/M_Data/M_Last output beat stream, L lanes x 16 bits
//   Busy          frame in progress (state != IDLE)
//   Done          one-cycle pulse when the frame has fully drained

`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module conv_unzero #(
  parameter int CHANNEL_IN_NUM = 8,
  parameter int BEAT_CNT_WIDTH = 16
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  Start,
  input  logic [BEAT_CNT_WIDTH-1:0]                             beat_total,
  input  logic [7:0]                                            zero_data_in,
  input  logic                                                  S_Valid,
  output logic                                                  S_Ready,
  input  logic [`PICTURE_NUM*CHANNEL_IN_NUM*`WIDTH_DATA-1:0]    S_Data,
  output logic                                                  M_Valid,
  input  logic                                                  M_Ready,
  output logic [`PICTURE_NUM*CHANNEL_IN_NUM*`WIDTH_DATA*2-1:0]  M_Data,
  output logic                                                  M_Last,
  output logic                                                  Busy,
  output logic                                                  Done
);

  localparam int LANES = `PICTURE_NUM * CHANNEL_IN_NUM;
  localparam int SW    = LANES * `WIDTH_DATA;
  localparam int MW    = SW * 2;

  localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ZERO = {BEAT_CNT_WIDTH{1'b0}};
  localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE  = {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Each lane is zero-extended to 16 bits before subtracting, so the upper
  // byte of the result is exactly the sign extension of the -255..+255 range.
  function automatic logic [MW-1:0] unzero_beat(input logic [SW-1:0] x,
                                                input logic [7:0]    zp);
    logic [MW-1:0] r;
    r = {MW{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      r[k*16 +: 16] = {8'h00, x[k*8 +: 8]} - {8'h00, zp};
    end
    return r;
  endfunction

  state_t                    state_r, state_nxt_s;
  logic [BEAT_CNT_WIDTH-1:0] remain_r, remain_nxt_s;
  logic [7:0]                zp_r, zp_nxt_s;
  logic                      done_r, done_nxt_s;

  logic                      s1_valid_r;
  logic                      s1_last_r;
  logic [MW-1:0]             s1_diff_r;

  logic                      m_valid_r;
  logic                      m_last_r;
  logic [MW-1:0]             m_data_r;

  logic                      s2_load_s;
  logic                      s_ready_s;
  logic                      s_accept_s;

  // Pipeline handshake: stage2 takes stage1 when it is empty or being drained;
  // the input is accepted in RUN when stage1 is empty or advancing.
  always_comb begin
    s2_load_s  = s1_valid_r && (!m_valid_r || M_Ready);
    s_ready_s  = (state_r == ST_RUN) && (!s1_valid_r || s2_load_s);
    s_accept_s = S_Valid && s_ready_s;
  end

  // Frame control next-state logic.
  always_comb begin
    state_nxt_s  = state_r;
    remain_nxt_s = remain_r;
    zp_nxt_s     = zp_r;
    done_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A Start coinciding with the Done pulse is dropped so back-to-back
        // frames always see one clean IDLE cycle.
        if (Start && !done_r) begin
          zp_nxt_s     = zero_data_in;
          remain_nxt_s = (beat_total == CNT_ZERO) ? CNT_ONE : beat_total;
          state_nxt_s  = ST_RUN;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (s_accept_s) begin
          remain_nxt_s = remain_r - CNT_ONE;
          if (remain_r == CNT_ONE) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_r && !m_valid_r) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Frame control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      remain_r <= CNT_ZERO;
      zp_r     <= 8'h00;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      remain_r <= remain_nxt_s;
      zp_r     <= zp_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  // Stage1: captured input beat, its last flag and the per-lane difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_diff_r  <= {MW{1'b0}};
    end else if (s_accept_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= (remain_r == CNT_ONE);
      s1_diff_r  <= unzero_beat(S_Data, zp_r);
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end
  end

  // Stage2: output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= {MW{1'b0}};
    end else if (s2_load_s) begin
      m_valid_r <= 1'b1;
      m_last_r  <= s1_last_r;
      m_data_r  <= s1_diff_r;
    end else if (M_Ready) begin
      // Last is cleared with valid so it never shows on an empty output.
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end
  end

  assign S_Ready = s_ready_s;
  assign M_Valid = m_valid_r;
  assign M_Last  = m_last_r;
  assign M_Data  = m_data_r;
  assign Busy    = (state_r != ST_IDLE);
  assign Done    = done_r;

endmodule

// File: tb/tb_conv_unzero.sv
// Self-checking bench for conv_unzero: randomized frames checked against a
// queue-based reference model of the beat stream.

`ifndef PICTURE_NUM
`define PICTURE_NUM 2
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module tb_conv_unzero;

  localparam int CIN = 8;
  localparam int CW  = 16;
  localparam int L   = `PICTURE_NUM * CIN;
  localparam int SW  = L * `WIDTH_DATA;
  localparam int MW  = SW * 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [CW-1:0] beat_total;
  logic [7:0]    zero_data_in;
  logic          S_Valid;
  logic          S_Ready;
  logic [SW-1:0] S_Data;
  logic          M_Valid;
  logic          M_Ready;
  logic [MW-1:0] M_Data;
  logic          M_Last;
  logic          Busy;
  logic          Done;

  conv_unzero #(.CHANNEL_IN_NUM(CIN), .BEAT_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .Start(Start), .beat_total(beat_total),
    .zero_data_in(zero_data_in), .S_Valid(S_Valid), .S_Ready(S_Ready),
    .S_Data(S_Data), .M_Valid(M_Valid), .M_Ready(M_Ready), .M_Data(M_Data),
    .M_Last(M_Last), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(string tag, logic [MW-1:0] got, logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [MW-1:0] data;
    logic          last;
    int            acc_cyc;
  } exp_t;

  exp_t          q[$];
  logic [MW-1:0] out_log[$];
  logic          last_log[$];
  bit            mon_en = 0;
  bit            busy_m = 0;
  int            total_m = 0;
  int            acc_m = 0;
  logic [7:0]    zp_m = 8'd0;
  int            cyc = 0;
  int            last_out_cyc = -100;
  bit            late_rep = 0;
  bit            lat_chk = 0;
  int            mr_mode = 0;
  int            srdy_run = 0;
  int            srdy_max = 0;
  bit            prev_stall = 0;
  bit            prev_rst = 0;
  logic [MW-1:0] prev_data;
  logic          prev_last;

  // Expected output beat: each lane is x - zp as plain integer arithmetic.
  function automatic logic [MW-1:0] ref_beat(logic [SW-1:0] x, logic [7:0] zp);
    logic [MW-1:0] r;
    int d;
    r = '0;
    for (int k = 0; k < L; k++) begin
      d = int'(x[k*8 +: 8]) - int'(zp);
      r[k*16 +: 16] = d[15:0];
    end
    return r;
  endfunction

  // Monitor: compares outputs, then applies the upcoming edge to the model.
  always @(negedge clk) begin
    exp_t e;
    bit   drained;
    bit   exp_srdy;
    cyc++;
    if (mon_en) begin
      if (prev_stall && !prev_rst) begin
        check_val("stall_valid", M_Valid, 1'b1);
        check_val("stall_data", M_Data, prev_data);
        check_val("stall_last", M_Last, prev_last);
      end
      if (!M_Valid) check_val("last_when_idle", M_Last, 1'b0);

      drained = busy_m && (acc_m == total_m) && (q.size() == 0);
      if (Done) begin
        check_val("done_legal", drained && ((cyc - last_out_cyc) <= 3), 1'b1);
        check_val("done_no_mvalid", M_Valid, 1'b0);
        busy_m = 0;
      end else if (drained && (cyc - last_out_cyc) > 3 && !late_rep) begin
        late_rep = 1;
        check_val("done_late", 1'b0, 1'b1);
      end
      check_val("busy", Busy, busy_m);

      exp_srdy = busy_m && (acc_m < total_m) && (q.size() < 2 || M_Ready);
      check_val("s_ready", S_Ready, exp_srdy);
      if (S_Ready) begin
        srdy_run++;
        if (srdy_run > srdy_max) srdy_max = srdy_run;
      end else begin
        srdy_run = 0;
      end

      if (M_Valid && M_Ready) begin
        if (q.size() == 0) begin
          check_val("spurious_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check_val("m_data", M_Data, e.data);
          check_val("m_last", M_Last, e.last);
          if (lat_chk) check_val("latency", cyc - e.acc_cyc, 2);
        end
        out_log.push_back(M_Data);
        last_log.push_back(M_Last);
        last_out_cyc = cyc;
      end

      if (S_Valid && S_Ready) begin
        acc_m++;
        e.data = ref_beat(S_Data, zp_m);
        e.last = (acc_m == total_m);
        e.acc_cyc = cyc;
        q.push_back(e);
      end

      if (Start && !busy_m && !Done) begin
        busy_m   = 1;
        zp_m     = zero_data_in;
        total_m  = (beat_total == '0) ? 1 : int'(beat_total);
        acc_m    = 0;
        late_rep = 0;
      end

      if (rst) begin
        q.delete();
        busy_m  = 0;
        acc_m   = 0;
        total_m = 0;
      end
    end
    prev_stall = M_Valid && !M_Ready;
    prev_data  = M_Data;
    prev_last  = M_Last;
    prev_rst   = rst;
  end

  // Downstream ready generator.
  initial begin
    int tg = 0;
    M_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0: M_Ready = 1'b1;
        1: begin
          M_Ready = ((tg % 4) == 0) || ((tg % 4) == 3);
          tg++;
        end
        2: M_Ready = ($urandom_range(0, 2) != 0);
        default: M_Ready = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(int total, logic [7:0] zp);
    beat_total   = total[CW-1:0];
    zero_data_in = zp;
    Start        = 1'b1;
    tick();
    Start        = 1'b0;
    beat_total   = CW'($urandom);
    zero_data_in = 8'($urandom);
  endtask

  // dmode: 0 = all lanes val, 1 = random lanes, 2 = table 0,128,255,1
  task automatic send_beats(int n, bit full, int dmode, logic [7:0] val);
    int   sent = 0;
    int   guard = 0;
    bit   need = 1;
    logic [7:0] tbl [4] = '{8'd0, 8'd128, 8'd255, 8'd1};
    while (sent < n && guard < 4000) begin
      if (need) begin
        for (int k = 0; k < L; k++) begin
          case (dmode)
            0:       S_Data[k*8 +: 8] = val;
            1:       S_Data[k*8 +: 8] = 8'($urandom);
            default: S_Data[k*8 +: 8] = tbl[sent % 4];
          endcase
        end
        need = 0;
      end
      S_Valid = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (S_Valid && S_Ready) begin
        sent++;
        need = 1;
      end
      tick();
      guard++;
    end
    S_Valid = 1'b0;
    check_val("send_count", sent, n);
  endtask

  task automatic wait_done(int bound, bit restart);
    bit seen = 0;
    int n = 0;
    while (!seen && n < bound) begin
      @(negedge clk);
      if (Done === 1'b1) seen = 1;
      n++;
    end
    check_val("done_seen", seen, 1'b1);
    if (seen && restart) begin
      Start = 1'b1;
      beat_total = 16'd3;
      @(posedge clk);
      #1;
      Start = 1'b0;
      @(negedge clk);
      check_val("start_at_done_busy", Busy, 1'b0);
    end
    tick();
  endtask

  initial begin
    logic [15:0] t1_exp [4] = '{16'hFF80, 16'h0000, 16'h007F, 16'hFF81};
    int tot;
    rst = 1'b1; Start = 1'b0; beat_total = '0; zero_data_in = 8'd0;
    S_Valid = 1'b0; S_Data = '0;
    tick();
    mon_en = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_m_valid", M_Valid, 1'b0);
    check_val("rst_m_data", M_Data, '0);
    check_val("rst_m_last", M_Last, 1'b0);
    check_val("rst_s_ready", S_Ready, 1'b0);
    check_val("rst_busy", Busy, 1'b0);
    check_val("rst_done", Done, 1'b0);
    tick();

    // Basic frame at full downstream rate.
    mr_mode = 0; lat_chk = 1; out_log.delete(); last_log.delete();
    start_frame(4, 8'd128);
    send_beats(4, 1, 2, 8'd0);
    wait_done(40, 0);
    check_val("t1_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check_val("t1_lane0", out_log[i][15:0], t1_exp[i]);
      check_val("t1_lane_top", out_log[i][MW-1 -: 16], t1_exp[i]);
      check_val("t1_last", last_log[i], (i == 3));
    end

    // Same frame with a stalling consumer.
    mr_mode = 1; lat_chk = 0; out_log.delete();
    start_frame(4, 8'd128);
    send_beats(4, 1, 2, 8'd0);
    wait_done(60, 0);
    check_val("t2_count", out_log.size(), 4);

    // beat_total of zero behaves as a single beat.
    mr_mode = 0; lat_chk = 1; out_log.delete(); last_log.delete();
    start_frame(0, 8'd0);
    send_beats(1, 1, 0, 8'hAB);
    wait_done(40, 0);
    check_val("t3_count", out_log.size(), 1);
    if (out_log.size() > 0) begin
      check_val("t3_lane0", out_log[0][15:0], 16'h00AB);
      check_val("t3_last", last_log[0], 1'b1);
    end

    // Mid-frame zero point change and a spurious Start.
    mr_mode = 2; lat_chk = 0; out_log.delete();
    start_frame(6, 8'd10);
    zero_data_in = 8'd200;
    send_beats(3, 0, 1, 8'd0);
    Start = 1'b1; beat_total = 16'd2;
    tick();
    Start = 1'b0;
    send_beats(3, 0, 1, 8'd0);
    wait_done(80, 0);
    check_val("t4_count", out_log.size(), 6);

    // Reset in the middle of a stalled frame.
    mr_mode = 3;
    start_frame(5, 8'($urandom));
    send_beats(2, 1, 1, 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("t5_m_valid", M_Valid, 1'b0);
    check_val("t5_busy", Busy, 1'b0);
    check_val("t5_s_ready", S_Ready, 1'b0);
    tick();
    mr_mode = 2; out_log.delete();
    start_frame(7, 8'($urandom));
    send_beats(7, 0, 1, 8'd0);
    wait_done(80, 0);
    check_val("t5_count", out_log.size(), 7);

    // Long frame at full throughput, everything cancels to zero.
    mr_mode = 0; lat_chk = 1; out_log.delete(); srdy_max = 0;
    start_frame(256, 8'd255);
    send_beats(256, 1, 0, 8'd255);
    wait_done(40, 0);
    check_val("t6_count", out_log.size(), 256);
    check_val("t6_srdy_run", srdy_max, 256);

    // Random frames; one of them tries a Start on the Done cycle.
    lat_chk = 0;
    for (int f = 0; f < 6; f++) begin
      mr_mode = 2; out_log.delete();
      tot = $urandom_range(0, 12);
      start_frame(tot, 8'($urandom));
      send_beats((tot == 0) ? 1 : tot, 0, 1, 8'd0);
      wait_done(120, (f == 2));
      check_val("t7_count", out_log.size(), (tot == 0) ? 1 : tot);
    end

    check_val("model_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
